// File: rtl/lpf_pkg.sv
// Shared types and helpers for the multi-channel boxcar low-pass filter.
package lpf_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } lpf_state_t;

    // Running-sum width: enough headroom for PERIOD+1 samples of W bits
    function automatic int lpf_sum_w(input int w, input int period);
        return w + $clog2(period + 1);
    endfunction

    // Clamp a signed value to the range of a signed 'width'-bit number
    function automatic logic signed [63:0] lpf_sat(input logic signed [63:0] value,
                                                   input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/lpf_sample_ram.sv
// Sample history RAM: simple dual port, synchronous read and write,
// read-before-write on a shared address, contents not reset.
module lpf_sample_ram
    import lpf_pkg::*;
#(
    parameter int DEPTH = 36,
    parameter int WIDTH = 10,
    parameter int AW    = 6
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Registered read returns the pre-write contents on an address collision
    always_ff @(posedge CLK) begin
        if (RE) RDATA <= mem[RADDR];
        if (WE) mem[WADDR] <= WDATA;
    end

endmodule

// File: rtl/lpf_boxcar_mc.sv
// Time-multiplexed multi-channel moving-average filter with decimated ticks,
// rational gain and output saturation. One adder and one RAM serve every
// channel; all channels of OUT change together.
// Build option: define LPF_ROUNDING_EN for round-half-away-from-zero scaling;
// without it the scaling truncates toward zero.
module lpf_boxcar_mc
    import lpf_pkg::*;
#(
    parameter int CHANNELS         = 2,
    parameter int SIGNAL_BIT_WIDTH = 10,
    parameter int PERIOD           = 18,
    parameter int DIV_RATIO        = 4,
    parameter int GAIN_M           = 1,
    parameter int GAIN_D           = 16
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 CLK_EN,
    input  logic [CHANNELS*SIGNAL_BIT_WIDTH-1:0] IN,
    output logic [CHANNELS*SIGNAL_BIT_WIDTH-1:0] OUT,
    output logic                                 OUT_VALID,
    output logic                                 BUSY,
    output logic                                 OVERRUN
);

    localparam int W     = SIGNAL_BIT_WIDTH;
    localparam int SUM_W = lpf_sum_w(W, PERIOD);
    localparam int PW    = SUM_W + $clog2(GAIN_M + 1);
`ifdef LPF_ROUNDING_EN
    localparam int QW    = PW + 1;
`else
    localparam int QW    = PW;
`endif
    localparam int DEPTH = CHANNELS * PERIOD;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W = $clog2(PERIOD);
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam int DIV_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;

    localparam logic signed [PW-1:0] GM = PW'(GAIN_M);
    localparam logic signed [QW-1:0] GD = QW'(GAIN_D);
`ifdef LPF_ROUNDING_EN
    localparam logic signed [QW-1:0] HALF = QW'(GAIN_D / 2);
`endif

    lpf_state_t                  state;
    logic [DIV_W-1:0]            div;
    logic                        tick;
    logic [CH_W-1:0]             ch;
    logic [IDX_W-1:0]            index;
    logic [CNT_W-1:0]            count;
    logic [CHANNELS-1:0][W-1:0]  snap;
    logic [CHANNELS-1:0][W-1:0]  stage;
    logic [CHANNELS-1:0][W-1:0]  stage_next;
    logic signed [SUM_W-1:0]     sum [CHANNELS];
    logic signed [SUM_W-1:0]     sum_next;
    logic signed [PW-1:0]        prod;
    logic signed [QW-1:0]        biased;
    logic signed [QW-1:0]        quot;
    logic [W-1:0]                sat_val;
    logic [W-1:0]                old;
    logic [AW-1:0]               addr;
    logic                        ram_we;
    logic                        ram_re;

    assign tick   = CLK_EN && (div == DIV_W'(DIV_RATIO - 1));
    assign addr   = AW'(ch) * AW'(PERIOD) + AW'(index);
    assign ram_re = (state == ST_READ);
    // A write landing in a reset cycle would corrupt history of an aborted sweep
    assign ram_we = (state == ST_UPDATE) && !RESET;

    lpf_sample_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .WE    (ram_we),
        .WADDR (addr),
        .WDATA (snap[ch]),
        .RE    (ram_re),
        .RADDR (addr),
        .RDATA (old)
    );

    // Shared datapath for the channel being updated: sum, gain, saturate
    always_comb begin
        sum_next = sum[ch] + SUM_W'($signed(snap[ch]));
        // During warm-up the RAM slot holds stale data, so it is never subtracted
        if (count == CNT_W'(PERIOD))
            sum_next = sum_next - SUM_W'($signed(old));
        prod = PW'(sum_next) * GM;
`ifdef LPF_ROUNDING_EN
        if (prod < 0)
            biased = QW'(prod) - HALF;
        else if (prod > 0)
            biased = QW'(prod) + HALF;
        else
            biased = '0;
`else
        biased = QW'(prod);
`endif
        quot       = biased / GD;
        sat_val    = W'(lpf_sat(64'(quot), W));
        stage_next = stage;
        stage_next[ch] = sat_val;
    end

    // Tick divider, sweep FSM and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            div       <= '0;
            ch        <= '0;
            index     <= '0;
            count     <= '0;
            snap      <= '0;
            stage     <= '0;
            for (int i = 0; i < CHANNELS; i++) sum[i] <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;

            if (CLK_EN) begin
                if (div == DIV_W'(DIV_RATIO - 1)) div <= '0;
                else                              div <= div + DIV_W'(1);
            end

            // Ticks are never queued; the running sweep is left untouched
            if (tick && state != ST_IDLE) OVERRUN <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        snap  <= IN;
                        ch    <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    sum[ch] <= sum_next;
                    stage   <= stage_next;
                    if (ch == CH_W'(CHANNELS - 1)) begin
                        // Publish on the edge into DONE so OUT is visible during DONE
                        OUT       <= stage_next;
                        OUT_VALID <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    if (index == IDX_W'(PERIOD - 1)) index <= '0;
                    else                             index <= index + IDX_W'(1);
                    if (count != CNT_W'(PERIOD))     count <= count + CNT_W'(1);
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lpf_boxcar_mc.md
# lpf_boxcar_mc

Multi-channel, time-multiplexed moving-average (boxcar) low-pass filter for cartridge sound paths. It is the parametrised successor to the single-channel OPLL output LPF: configurable channel count, width, window length, decimation and gain. One shared adder and one sample RAM serve all channels, and every tick produces a coherent, saturated output vector. It sits between a sound generator (OPLL/PSG/SCC outputs) and the limiter/mixer feeding `SOUND_IF`.

## Interface
- `CHANNELS`, 2: number of independent signed channels.
- `SIGNAL_BIT_WIDTH`, 10: signed sample width, for both input and output.
- `PERIOD`, 18: window length in ticks; must be ≥ 2.
- `DIV_RATIO`, 4: number of `CLK_EN` pulses per filter tick; must be ≥ 1.
- `GAIN_M`, 1: gain numerator; must be ≥ 1.
- `GAIN_D`, 16: gain denominator; must be ≥ 1.

- `CLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high reset.
- `CLK_EN`  in  1  sample-rate enable, one `CLK` wide.
- `IN`  in  `CHANNELS*SIGNAL_BIT_WIDTH`  packed signed samples; channel 0 occupies the LSBs.
- `OUT`  out  `CHANNELS*SIGNAL_BIT_WIDTH`  filtered samples, same packing as `IN`.
- `OUT_VALID`  out  1  one-cycle pulse when `OUT` is updated.
- `BUSY`  out  1  a channel sweep is in progress.
- `OVERRUN`  out  1  sticky: a tick arrived while `BUSY` was high.

## Operation
- Divider `div`, range 0..`DIV_RATIO`-1:
  - Increments on `CLK_EN`.
  - A tick is a cycle with `CLK_EN` high and `div == DIV_RATIO-1`; `div` wraps to 0 on that cycle.
- On a tick with the FSM in IDLE: snapshot `IN` into `snap`, set `ch` = 0, and go to READ.
- On a tick with the FSM not in IDLE: the tick is dropped, `OVERRUN` is set, and the sweep in progress continues unaffected.
- FSM states: IDLE → READ → UPDATE → (READ if `ch < CHANNELS-1`, else DONE) → IDLE.
  - READ: present RAM address `ch*PERIOD + index`. The RAM has one-cycle read latency.
  - UPDATE:
    - `sum[ch] += snap[ch] - old` when `count == PERIOD`, otherwise `sum[ch] += snap[ch]`.
    - Write `snap[ch]` to the same RAM address.
    - Write `sat(scale(sum_next))` to `stage[ch]`.
    - Increment `ch`.
  - DONE:
    - `OUT <= stage` (all channels update together).
    - Pulse `OUT_VALID`.
    - `index` wraps at `PERIOD-1`.
    - `count` increments, saturating at `PERIOD`.
- Arithmetic:
  - `SUM_W = SIGNAL_BIT_WIDTH + $clog2(PERIOD+1)`, signed.
  - Product width is `SUM_W + $clog2(GAIN_M+1)`.
  - `scale(s) = s*GAIN_M / GAIN_D`, signed; rounding mode is set under Configuration.
  - `sat` clamps to [-2^(W-1), 2^(W-1)-1].
- Warm-up: RAM contents are not reset. While `count < PERIOD`, old values are never read into `sum`.

## Timing
- Reset values: `OUT` = 0, `OUT_VALID` = 0, `BUSY` = 0, `OVERRUN` = 0. All `sum`, `stage`, `snap`, `index`, `count` and `div` are cleared, and the FSM returns to IDLE.
- Tick in cycle t: `BUSY` is high in cycles t+1 .. t+2·CHANNELS+1.
- `OUT` and `OUT_VALID` are visible in cycle t+2·CHANNELS+1, i.e. the cycle after DONE's registering edge.
- Minimum tick spacing without overrun is 2·CHANNELS+2 cycles.
- `RESET` in any state aborts the sweep.
  - No partial `OUT` update occurs.
  - Any RAM write issued in the reset cycle is suppressed.
- `OVERRUN` clears only on `RESET`.
- A tick may coincide with the DONE cycle. It is counted as an overrun; it does not start a new sweep.

## Configuration
- `LPF_ROUNDING_EN` defined:
  - `scale` adds `sign(p)·(GAIN_D/2)` to the product before dividing (round half away from zero).
  - The sum is taken at product width plus one bit, so it cannot overflow.
- Undefined: `scale` uses truncating signed division (toward zero).

## Structure
- Package `lpf_pkg`:
  - FSM state enum `lpf_state_t`.
  - Function `lpf_sat(value, width)`.
  - Width helper `lpf_sum_w(W, PERIOD)`.
- Sub-module `lpf_sample_ram`:
  - Simple dual-port memory, depth `CHANNELS*PERIOD`, width `SIGNAL_BIT_WIDTH`.
  - Synchronous read and write, read-before-write on the same address.
  - No reset.

## Test plan
Unless stated otherwise, the bench uses `CHANNELS`=2, W=10, `PERIOD`=18, `DIV_RATIO`=4, gain 1/16.

- Step: ch0 = +100, ch1 = -100 constant.
  - After tick k ≤ 18, `OUT` = ±trunc(100k/16); at k=18, ±112.
  - With `LPF_ROUNDING_EN`, k=18 gives ±113.
  - Value holds for all later ticks.
- Decay / wrap:
  - After 18 ticks of +100, drive 0; `OUT` reaches 0 on the 18th subsequent tick.
  - `index` wraps 17→0 with no glitch.
  - Over 100 ticks, `sum` is checked against a software model every tick.
- Saturation: gain 1/1, ch0 = +511, ch1 = -512.
  - From tick 2 on, `OUT` = +511 / -512.
  - Internal sum at steady state is +9198 / -9216 with no wrap.
- Latency:
  - `OUT_VALID` pulses exactly once per tick, at t+5.
  - `BUSY` is high for t+1..t+5.
  - `CLK_EN` pulses 1–3 of each group produce no activity.
- Overrun: `DIV_RATIO`=1, `CLK_EN` every 3 cycles.
  - `OVERRUN` sets on the first dropped tick.
  - The sweep in progress still completes correctly.
- Reset mid-sweep: assert `RESET` in the UPDATE state of ch1.
  - Next cycle: all outputs are 0 and the FSM is in IDLE.
  - After restart, the warm-up sequence matches the step test exactly.
